// File: rtl/pipe_reg_chain_if.sv
// ============================================================================
// Module  : pipe_reg_chain_if
// Purpose : Handshake, control and status bundle for the pipeline register chain.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pipe_reg_chain_if #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 4,
   parameter int CNT_W  = 32
);
   logic                      in_valid;
   logic [WIDTH-1:0]          in_data;
   logic                      in_ready;
   logic [STAGES-1:0]         stall;
   logic [STAGES-1:0]         flush;
   logic                      count_clr;
   logic [STAGES-1:0]         stage_valid;
   logic [STAGES*WIDTH-1:0]   stage_data;
   logic                      retire_valid;
   logic [CNT_W-1:0]          retire_count;
   logic [CNT_W-1:0]          stall_count;

   modport master (
      output in_valid, in_data, stall, flush, count_clr,
      input  in_ready, stage_valid, stage_data, retire_valid, retire_count, stall_count
   );

   modport slave (
      input  in_valid, in_data, stall, flush, count_clr,
      output in_ready, stage_valid, stage_data, retire_valid, retire_count, stall_count
   );
endinterface

`default_nettype wire

// File: rtl/pipe_reg_chain.sv
// ============================================================================
// Module  : pipe_reg_chain
// Purpose : Stallable/flushable pipeline register chain with bubble collapse and
//           saturating retire/stall counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_reg_chain #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 4,
   parameter int CNT_W  = 32
) (
   input  wire logic         clk,
   input  wire logic         rst,
   pipe_reg_chain_if.slave   bus
);

   logic [STAGES-1:0] valid_q, valid_d;
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  data_d [STAGES];
   logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic [STAGES-1:0] w_ev, w_hold, w_up_valid;
   logic [WIDTH-1:0]  w_up_data [STAGES];
   logic              w_in_ready, w_retire;

   // Back-pressure walks from the tail; a bubble stage absorbs it.
   function automatic logic [STAGES-1:0] f_hold(input logic [STAGES-1:0] st,
                                                input logic [STAGES-1:0] ev);
      logic [STAGES-1:0] h;
      h = '0;
      h[STAGES-1] = st[STAGES-1];
      for (int i = STAGES - 2; i >= 0; i--) begin
         h[i] = st[i] | (ev[i] & h[i+1]);
      end
      return h;
   endfunction

   assign w_ev       = valid_q & ~bus.flush;
   assign w_hold     = f_hold(bus.stall, w_ev);
   assign w_in_ready = rst ? ~bus.stall[0] : ~w_hold[0];
   assign w_retire   = w_ev[STAGES-1] & ~w_hold[STAGES-1] & ~rst;

   generate
      for (genvar i = 0; i < STAGES; i++) begin : g_stage
         if (i == 0) begin : g_head
            assign w_up_valid[i] = bus.in_valid;
            assign w_up_data[i]  = bus.in_data;
         end else begin : g_body
            assign w_up_valid[i] = w_ev[i-1] & ~w_hold[i-1];
            assign w_up_data[i]  = data_q[i-1];
         end
         assign bus.stage_data[i*WIDTH +: WIDTH] = data_q[i];
      end
   endgenerate

   always_comb begin
      valid_d = '0;
      for (int i = 0; i < STAGES; i++) begin
         data_d[i]  = '0;
         valid_d[i] = w_hold[i] ? w_ev[i] : w_up_valid[i];
         if (valid_d[i]) begin
            data_d[i] = w_hold[i] ? data_q[i] : w_up_data[i];
         end
      end
   end

   always_comb begin
      retire_cnt_d = retire_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      if (bus.count_clr) begin
         retire_cnt_d = '0;
         stall_cnt_d  = '0;
      end else begin
         if (w_retire && (retire_cnt_q != '1)) retire_cnt_d = retire_cnt_q + CNT_W'(1);
         if (!w_in_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= '0;
         retire_cnt_q <= '0;
         stall_cnt_q  <= '0;
         for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
      end else begin
         valid_q      <= valid_d;
         retire_cnt_q <= retire_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
         for (int i = 0; i < STAGES; i++) data_q[i] <= data_d[i];
      end
   end

   assign bus.in_ready     = w_in_ready;
   assign bus.stage_valid  = valid_q;
   assign bus.retire_valid = w_retire;
   assign bus.retire_count = retire_cnt_q;
   assign bus.stall_count  = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
// ============================================================================
// Module  : tb_pipe_reg_chain
// Purpose : Self-checking bench for pipe_reg_chain (scoreboard plus directed scenarios).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_reg_chain;
   localparam int W  = 16;
   localparam int S  = 4;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_reg_chain_if #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) bus();
   pipe_reg_chain #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;
   bit sb_on  = 1'b0;
   logic [W-1:0] sb_q [$];
   logic [W-1:0] sb_exp;
   int rv_cycles, rv_run, rv_maxrun;

   function automatic logic [W-1:0] sd(input int i);
      return bus.stage_data[i*W +: W];
   endfunction

   // Inputs change 1 time unit after the edge; checks happen 4 units after it.
   task automatic step(input logic v, input logic [W-1:0] d, input logic [S-1:0] st,
                       input logic [S-1:0] fl, input logic clr, input logic r);
      @(posedge clk);
      #1;
      bus.in_valid = v; bus.in_data = d; bus.stall = st; bus.flush = fl;
      bus.count_clr = clr; rst = r;
      #3;
   endtask

   task automatic idle();
      step(1'b0, '0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, '0, '0, '0, 1'b0, 1'b1);
   endtask

   task automatic fill(input logic [W-1:0] base);
      for (int k = 1; k <= 4; k++) step(1'b1, base + W'(k), '0, '0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (sb_on) begin
         if (rst) begin
            sb_q.delete();
         end else begin
            if (bus.retire_valid) begin
               checks++;
               if (sb_q.size() == 0) begin
                  errors++;
                  $display("FAIL sb_retire: retired %h, expected no retirement", sd(S-1));
               end else begin
                  sb_exp = sb_q.pop_front();
                  if (sd(S-1) !== sb_exp) begin
                     errors++;
                     $display("FAIL sb_retire: data %h, expected %h", sd(S-1), sb_exp);
                  end
               end
            end
            if (bus.in_valid) sb_q.push_back(bus.in_data);
         end
      end
   end

   task automatic test_reset();
      do_reset();
      idle();
      fill(16'hA000);
      step(1'b1, 16'hA0FF, 4'b1000, '0, 1'b0, 1'b1);
      checks++; if (bus.stage_valid !== 4'b1111) begin errors++; $display("FAIL rst_prefill: valid %b, expected 1111", bus.stage_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b, expected 1", bus.in_ready); end
      checks++; if (bus.retire_valid !== 1'b0) begin errors++; $display("FAIL rst_no_retire: got %b, expected 0", bus.retire_valid); end
      idle();
      checks++; if (bus.stage_valid !== 4'b0000) begin errors++; $display("FAIL rst_valid: got %b, expected 0000", bus.stage_valid); end
      checks++; if (bus.stage_data !== '0) begin errors++; $display("FAIL rst_data: got %h, expected 0", bus.stage_data); end
      checks++; if (bus.retire_count !== '0 || bus.stall_count !== '0) begin errors++; $display("FAIL rst_counts: got %h/%h, expected 0/0", bus.retire_count, bus.stall_count); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_after_ready: got %b, expected 1", bus.in_ready); end
   endtask

   task automatic test_stream();
      sb_on = 1'b1;
      do_reset();
      rv_cycles = 0; rv_run = 0; rv_maxrun = 0;
      for (int k = 1; k <= 14; k++) begin
         if (k <= 8) step(1'b1, W'(k), '0, '0, 1'b0, 1'b0);
         else idle();
         if (k == 5) begin
            checks++; if (sd(3) !== 16'h0001 || bus.stage_valid !== 4'b1111) begin errors++; $display("FAIL stream_latency: s3=%h valid=%b, expected 0001/1111", sd(3), bus.stage_valid); end
         end
         if (bus.retire_valid) begin
            rv_cycles++; rv_run++;
            if (rv_run > rv_maxrun) rv_maxrun = rv_run;
         end else begin
            rv_run = 0;
         end
      end
      checks++; if (rv_cycles != 8 || rv_maxrun != 8) begin errors++; $display("FAIL stream_retire_run: cycles=%0d run=%0d, expected 8/8", rv_cycles, rv_maxrun); end
      checks++; if (bus.retire_count !== 4'd8) begin errors++; $display("FAIL stream_count: got %0d, expected 8", bus.retire_count); end
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL stream_drain: %0d items left, expected 0", sb_q.size()); end
      sb_on = 1'b0;
   endtask

   task automatic test_stall();
      do_reset();
      fill(16'hB000);
      step(1'b1, 16'hB005, 4'b0100, '0, 1'b0, 1'b0);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b, expected 0", bus.in_ready); end
      checks++; if (bus.retire_valid !== 1'b1) begin errors++; $display("FAIL stall_retire: got %b, expected 1", bus.retire_valid); end
      idle();
      checks++; if (bus.stage_valid !== 4'b0111) begin errors++; $display("FAIL stall_valid: got %b, expected 0111", bus.stage_valid); end
      checks++; if (sd(0) !== 16'hB004 || sd(1) !== 16'hB003 || sd(2) !== 16'hB002 || sd(3) !== 16'h0) begin errors++; $display("FAIL stall_data: got %h, expected 0000b002b003b004", bus.stage_data); end
      checks++; if (bus.stall_count !== 4'd1) begin errors++; $display("FAIL stall_count: got %0d, expected 1", bus.stall_count); end
   endtask

   task automatic test_collapse();
      do_reset();
      step(1'b1, 16'hC001, '0, '0, 1'b0, 1'b0);
      step(1'b1, 16'hC002, '0, '0, 1'b0, 1'b0);
      idle();
      step(1'b1, 16'hC004, '0, '0, 1'b0, 1'b0);
      step(1'b1, 16'hC005, 4'b1000, '0, 1'b0, 1'b0);
      checks++; if (bus.stage_valid !== 4'b1101) begin errors++; $display("FAIL collapse_pre: valid %b, expected 1101", bus.stage_valid); end
      checks++; if (bus.in_ready !== 1'b1 || bus.retire_valid !== 1'b0) begin errors++; $display("FAIL collapse_hs: ready=%b retire=%b, expected 1/0", bus.in_ready, bus.retire_valid); end
      idle();
      checks++; if (bus.stage_valid !== 4'b1111) begin errors++; $display("FAIL collapse_valid: got %b, expected 1111", bus.stage_valid); end
      checks++; if (sd(0) !== 16'hC005 || sd(1) !== 16'hC004 || sd(2) !== 16'hC002 || sd(3) !== 16'hC001) begin errors++; $display("FAIL collapse_data: got %h, expected c001c002c004c005", bus.stage_data); end
      checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL collapse_stall_cnt: got %0d, expected 0", bus.stall_count); end
   endtask

   task automatic test_flush();
      do_reset();
      fill(16'hD000);
      step(1'b0, '0, 4'b0010, 4'b0011, 1'b0, 1'b0);
      checks++; if (bus.in_ready !== 1'b1 || bus.retire_valid !== 1'b1) begin errors++; $display("FAIL flush_hs: ready=%b retire=%b, expected 1/1", bus.in_ready, bus.retire_valid); end
      idle();
      checks++; if (bus.stage_valid !== 4'b1000) begin errors++; $display("FAIL flush_valid: got %b, expected 1000", bus.stage_valid); end
      checks++; if (sd(0) !== 16'h0 || sd(1) !== 16'h0 || sd(2) !== 16'h0 || sd(3) !== 16'hD002) begin errors++; $display("FAIL flush_data: got %h, expected d002000000000000", bus.stage_data); end
      checks++; if (bus.retire_count !== 4'd1) begin errors++; $display("FAIL flush_retire_cnt: got %0d, expected 1", bus.retire_count); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int k = 0; k < 20; k++) step(1'b1, 16'hE000 + W'(k), '0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) idle();
      checks++; if (bus.retire_count !== 4'hF) begin errors++; $display("FAIL sat_retire: got %h, expected f", bus.retire_count); end
      for (int k = 0; k < 17; k++) begin
         step(1'b0, '0, 4'b0001, '0, 1'b0, 1'b0);
         if (k == 5) begin
            checks++; if (bus.stall_count !== 4'd5) begin errors++; $display("FAIL stall_cnt_mid: got %0d, expected 5", bus.stall_count); end
         end
      end
      step(1'b0, '0, 4'b0001, '0, 1'b1, 1'b0);
      checks++; if (bus.stall_count !== 4'hF) begin errors++; $display("FAIL sat_stall: got %h, expected f", bus.stall_count); end
      idle();
      checks++; if (bus.retire_count !== 4'h0 || bus.stall_count !== 4'h0) begin errors++; $display("FAIL count_clr: got %h/%h, expected 0/0", bus.retire_count, bus.stall_count); end
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0; bus.stall = '0; bus.flush = '0; bus.count_clr = 1'b0;
      test_reset();
      test_stream();
      test_stall();
      test_collapse();
      test_flush();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
